// File: rtl/sort_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : sort_pkg                                                         |
// | Purpose : Shared types for the 16x32b sorting network and its consumers.   |
// |           SORT_W / SORT_N  element width and elements per block            |
// |           elem_t / block_t one element / one packed block                  |
// |           blk_elem()       element index -> element (element 0 is the MSW) |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package sort_pkg;

  localparam int SORT_W  = 32;
  localparam int SORT_N  = 16;
  localparam int SORT_IW = $clog2(SORT_N);

  typedef logic [SORT_W-1:0] elem_t;
  typedef elem_t [SORT_N-1:0] block_t;

  // The smallest element sits in the most significant word, so element k is
  // packed slot SORT_N-1-k.
  function automatic elem_t blk_elem(input block_t blk, input logic [SORT_IW-1:0] idx);
    logic [SORT_IW-1:0] pos;
    pos = SORT_IW'(SORT_N - 1) - idx;
    return blk[pos];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sorted_block_serializer_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : block_fifo                                                       |
// | Purpose : DEPTH-entry buffer of whole sorted blocks with occupancy count.  |
// | Ports   : clk, rst     clock / async active-high reset                     |
// |           push         write push_data at the write pointer                |
// |           push_data    block to store                                      |
// |           pop          retire the head entry                               |
// |           head         entry at the read pointer                           |
// |           count        occupancy, 0..DEPTH                                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module block_fifo #(
  parameter int BW    = 512,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [BW-1:0]          push_data,
  input  logic                   pop,
  output logic [BW-1:0]          head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_sel;
  logic [PW-1:0] rd_sel;

  generate
    if (DEPTH > 1) begin : g_ptr
      logic [PW-1:0] wr_ptr;
      logic [PW-1:0] rd_ptr;

      // DEPTH is a power of two, so the pointers wrap by plain overflow.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          wr_ptr <= '0;
          rd_ptr <= '0;
        end else begin
          if (push) wr_ptr <= wr_ptr + PW'(1);
          if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
      end

      assign wr_sel = wr_ptr;
      assign rd_sel = rd_ptr;
    end else begin : g_single
      assign wr_sel = '0;
      assign rd_sel = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_sel] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;  // idle, or simultaneous push/pop
      endcase
    end
  end

  assign head = mem[rd_sel];

endmodule
`default_nettype wire

// File: rtl/sorted_block_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sorted_block_serializer                                          |
// | Purpose : Buffers sorted blocks from the sorting network and emits their   |
// |           elements one per beat, smallest first, marking the last one.     |
// | Ports   : clk, rst   clock / async active-high reset                       |
// |           blk_valid  network has a sorted block on blk_data                |
// |           blk_data   block, element 0 in the MSW                           |
// |           blk_ready  room for a block; drives the network enable           |
// |           out_valid / out_data / out_last / out_ready  element stream      |
// |           blk_done   count of fully emitted blocks (wraps)                 |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module sorted_block_serializer
  import sort_pkg::*;
#(
  parameter int W     = SORT_W,
  parameter int N     = SORT_N,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           blk_valid,
  input  logic [N*W-1:0] blk_data,
  output logic           blk_ready,
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  input  logic           out_ready,
  output logic [15:0]    blk_done
);

  localparam int IW = $clog2(N);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0]  count;
  logic [N*W-1:0] head;
  logic [IW-1:0]  idx;
  logic [W-1:0]   sel;
  logic           push;
  logic           beat;
  logic           pop;

  // Readiness comes from occupancy alone: a pop in the same cycle does not
  // open a slot, which keeps out_ready off the network enable path.
  assign blk_ready = !rst && (count < CW'(DEPTH));
  assign push      = blk_valid && blk_ready;

  assign out_valid = (count != '0);
  assign beat      = out_valid && out_ready;
  assign pop       = beat && (idx == IW'(N - 1));

  block_fifo #(
    .BW    (N * W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (blk_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  generate
    if (N == SORT_N && W == SORT_W) begin : g_pkg_map
      assign sel = blk_elem(block_t'(head), idx);
    end else begin : g_generic_map
      logic [W-1:0] elems [N];
      for (genvar i = 0; i < N; i++) begin : g_split
        assign elems[i] = head[(N-1-i)*W +: W];
      end
      assign sel = elems[idx];
    end
  endgenerate

  assign out_data = out_valid ? sel : '0;
  assign out_last = out_valid && (idx == IW'(N - 1));

  // idx only moves on an accepted beat, so it holds during stalls and sits at
  // zero whenever the buffer is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      blk_done <= '0;
    end else if (beat) begin
      if (pop) begin
        idx      <= '0;
        blk_done <= blk_done + 16'd1;
      end else begin
        idx <= idx + IW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sorted_block_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sorted_block_serializer                                       |
// | Purpose : Directed self-checking bench for sorted_block_serializer.        |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_sorted_block_serializer;

  localparam int W = 32;
  localparam int N = 16;
  localparam int DEPTH = 2;

  logic           clk;
  logic           rst;
  logic           blk_valid;
  logic [N*W-1:0] blk_data;
  logic           blk_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic           out_ready;
  logic [15:0]    blk_done;

  sorted_block_serializer #(.W(W), .N(N), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .blk_valid (blk_valid),
    .blk_data  (blk_data),
    .blk_ready (blk_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .blk_done  (blk_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] blkmem [8][16];
  int          pend [$];
  logic [31:0] exp_d [$];
  logic        exp_l [$];
  logic [31:0] got_d [$];
  logic        got_l [$];
  int          got_c [$];
  int          pushes = 0;
  int          cyc = 0;
  logic        pat_mode = 1'b0;
  logic [3:0]  pat = 4'b1001;
  logic        stall_prev = 1'b0;
  logic [31:0] prev_d;
  logic        prev_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [N*W-1:0] pack(input int id);
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[(N-1-i)*W +: W] = blkmem[id][i];
    return r;
  endfunction

  task automatic start_feed();
    blk_data  = pack(pend[0]);
    blk_valid = 1'b1;
  endtask

  // One cycle: sample between edges, log the beat/push the next edge performs,
  // then advance to the following falling edge and update stimulus.
  task automatic tick();
    logic pushed;
    int   id;
    #1;
    if (stall_prev) begin
      chk("hold_data", out_data, prev_d);
      chk("hold_last", {31'd0, out_last}, {31'd0, prev_l});
    end
    stall_prev = out_valid && !out_ready;
    prev_d = out_data;
    prev_l = out_last;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
      got_c.push_back(cyc);
    end
    pushed = blk_valid && blk_ready;
    if (pushed) begin
      id = pend.pop_front();
      pushes++;
      for (int i = 0; i < N; i++) begin
        exp_d.push_back(blkmem[id][i]);
        exp_l.push_back(i == N - 1);
      end
    end
    @(negedge clk);
    cyc++;
    if (pushed) begin
      if (pend.size() != 0) blk_data = pack(pend[0]);
      else blk_valid = 1'b0;
    end
    if (pat_mode) out_ready = pat[cyc % 4];
  endtask

  task automatic drain(input int n, input int budget);
    int k = 0;
    while (got_d.size() < n && k < budget) begin
      tick();
      k++;
    end
    chk("drain_count", got_d.size(), n);
  endtask

  task automatic compare_stream(input string tag);
    int n;
    chk({tag, "_len"}, got_d.size(), exp_d.size());
    n = (got_d.size() < exp_d.size()) ? got_d.size() : exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_data"}, got_d[i], exp_d[i]);
      chk({tag, "_last"}, {31'd0, got_l[i]}, {31'd0, exp_l[i]});
    end
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      blkmem[0][i] = 32'h10 * (i + 1);
      blkmem[1][i] = 32'h1000 + i;
      blkmem[2][i] = 32'h2000 + i * 3;
      blkmem[3][i] = 32'h3000 + i;
      blkmem[4][i] = 32'hD000 + i * 16;
    end
    for (int b = 5; b < 8; b++) begin
      for (int i = 0; i < N; i++) blkmem[b][i] = $urandom;
      for (int i = 0; i < N - 1; i++)
        for (int j = 0; j < N - 1 - i; j++)
          if (blkmem[b][j] > blkmem[b][j+1]) begin
            logic [31:0] t;
            t = blkmem[b][j]; blkmem[b][j] = blkmem[b][j+1]; blkmem[b][j+1] = t;
          end
    end

    // Reset state
    rst = 1'b1; blk_valid = 1'b0; blk_data = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_blk_ready", {31'd0, blk_ready}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    chk("rst_blk_done", {16'd0, blk_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_blk_ready", {31'd0, blk_ready}, 32'd1);

    // Single block, sink always ready; element 0 visible right after the push edge
    out_ready = 1'b1;
    pend.push_back(0);
    start_feed();
    tick();
    #1;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_data", out_data, 32'h10);
    drain(16, 40);
    compare_stream("single");
    chk("single_done", {16'd0, blk_done}, 32'd1);

    // Backpressure with ready pattern 1,0,0,1
    pat_mode = 1'b1;
    out_ready = pat[cyc % 4];
    pend.push_back(0);
    start_feed();
    drain(16, 80);
    repeat (4) tick();
    compare_stream("bp");
    chk("bp_done", {16'd0, blk_done}, 32'd2);
    pat_mode = 1'b0;

    // Full stall: only DEPTH blocks accepted
    out_ready = 1'b0;
    pushes = 0;
    pend.push_back(1); pend.push_back(2); pend.push_back(3);
    start_feed();
    repeat (5) tick();
    chk("full_pushes", pushes, 2);
    chk("full_blk_ready", {31'd0, blk_ready}, 32'd0);
    blk_valid = 1'b0;
    pend.delete();
    out_ready = 1'b1;
    drain(16, 40);
    #1;
    chk("refill_blk_ready", {31'd0, blk_ready}, 32'd1);
    drain(32, 40);
    compare_stream("full");
    chk("full_done", {16'd0, blk_done}, 32'd4);

    // Back-to-back blocks with no bubble
    out_ready = 1'b1;
    pend.push_back(1); pend.push_back(2); pend.push_back(4);
    start_feed();
    drain(48, 100);
    if (got_c.size() == 48) chk("b2b_span", got_c[47] - got_c[0], 47);
    compare_stream("b2b");
    chk("b2b_done", {16'd0, blk_done}, 32'd7);

    // Reset mid-block with a second block buffered
    pend.push_back(1); pend.push_back(2);
    start_feed();
    drain(7, 30);
    rst = 1'b1;
    stall_prev = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_blk_ready", {31'd0, blk_ready}, 32'd0);
    chk("midrst_out_last", {31'd0, out_last}, 32'd0);
    blk_valid = 1'b0;
    pend.delete();
    @(negedge clk);
    rst = 1'b0;
    got_d.delete(); got_l.delete(); got_c.delete();
    exp_d.delete(); exp_l.delete();
    repeat (4) tick();
    chk("midrst_no_beats", got_d.size(), 0);
    chk("midrst_done", {16'd0, blk_done}, 32'd0);
    pend.push_back(4);
    start_feed();
    drain(16, 40);
    if (got_d.size() != 0) chk("midrst_first", got_d[0], 32'hD000);
    compare_stream("midrst");
    chk("midrst_done2", {16'd0, blk_done}, 32'd1);

    // Randomly filled blocks, sorted by the bench, under backpressure
    pat_mode = 1'b1;
    out_ready = pat[cyc % 4];
    pend.push_back(5); pend.push_back(6); pend.push_back(7);
    start_feed();
    drain(48, 200);
    compare_stream("e2e");
    chk("e2e_done", {16'd0, blk_done}, 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
